// File: rtl/array_pkg.sv
// Shared constants and state encoding for the array scan-out stage.
//   ARR_DEPTH / ARR_WIDTH / ARR_IDX_W : default array geometry (16 x 8 bits)
//   scan_state_t                      : scan FSM states
package array_pkg;
  localparam int ARR_DEPTH = 16;
  localparam int ARR_WIDTH = 8;
  localparam int ARR_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;
endpackage

// File: rtl/array_next_nz.sv
// Combinational eligible-entry finder.
//   mask  : one bit per array entry, 1 = entry may be emitted
//   cur   : current index
//   nxt   : lowest eligible index strictly greater than cur (valid when found)
//   found : some eligible index above cur exists
//   first : lowest eligible index overall (valid when any)
//   any   : at least one eligible index exists
module array_next_nz
  import array_pkg::*;
#(
  parameter int DEPTH = ARR_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] mask,
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] nxt,
  output logic             found,
  output logic [IDX_W-1:0] first,
  output logic             any
);

  // Walk from the top down so the last hit written is the lowest index.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    first = '0;
    any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) > cur)) begin
        nxt   = IDX_W'(i);
        found = 1'b1;
      end
      if (mask[i]) begin
        first = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/array_scan_out.sv
// Array scan-out: on start, snapshots a flattened DEPTH x WIDTH array and
// streams its entries lowest index first, one byte per beat, valid/ready.
// With SKIP_ZERO=1 zero entries are skipped without bubble cycles.
//   clk, rst_n       : clock, async active-low reset
//   start, arr_flat  : scan request (IDLE only) and array image
//   busy             : scan in progress
//   out_valid/ready  : beat handshake
//   out_data/idx/last: beat payload, entry index, final-beat flag
//   done             : one-cycle pulse after the final transfer
module array_scan_out
  import array_pkg::*;
#(
  parameter int DEPTH     = ARR_DEPTH,
  parameter int WIDTH     = ARR_WIDTH,
  parameter int SKIP_ZERO = 0,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DEPTH*WIDTH-1:0] arr_flat,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   done
);

  scan_state_t state, state_nx;
  logic [DEPTH*WIDTH-1:0] snap, src;
  logic [DEPTH-1:0]       mask;
  logic [IDX_W-1:0]       nxt, first, load_idx;
  logic                   any, ahead_found;
  logic                   load, capture;
  logic                   unused_found, unused_any;
  logic [IDX_W-1:0]       unused_nxt, unused_first;

  // In IDLE the snapshot is not loaded yet, so the first entry is chosen
  // straight from the live array on the capturing edge.
  assign src = (state == IDLE) ? arr_flat : snap;

  for (genvar g = 0; g < DEPTH; g++) begin : g_mask
    assign mask[g] = (SKIP_ZERO != 0) ? (|src[g*WIDTH +: WIDTH]) : 1'b1;
  end

  array_next_nz #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_cur (
    .mask (mask),
    .cur  (out_idx),
    .nxt  (nxt),
    .found(unused_found),
    .first(first),
    .any  (any)
  );

  assign load_idx = (state == IDLE) ? first : nxt;

  // Look-ahead from the entry being loaded: nothing eligible above it
  // means that entry is the final beat.
  array_next_nz #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ahead (
    .mask (mask),
    .cur  (load_idx),
    .nxt  (unused_nxt),
    .found(ahead_found),
    .first(unused_first),
    .any  (unused_any)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          state_nx = any ? SCAN : DONE;
          load     = any;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (out_last) state_nx = DONE;
          else          load     = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      if (capture) snap <= arr_flat;
      if (load) begin
        out_data <= src[load_idx*WIDTH +: WIDTH];
        out_idx  <= load_idx;
        out_last <= !ahead_found;
      end
    end
  end

  assign busy      = (state == SCAN);
  assign out_valid = (state == SCAN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_array_scan_out.sv
module tb_array_scan_out;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start0, start1, out_ready;
  logic [127:0] arr_flat;
  logic         busy0, v0, l0, done0, busy1, v1, l1, done1;
  logic [7:0]   d0, d1;
  logic [3:0]   i0, i1;

  int pass = 0;
  int total = 0;
  logic [12:0] q0[$];
  logic [12:0] q1[$];

  always #5 clk = ~clk;

  array_scan_out #(.SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .arr_flat(arr_flat),
    .busy(busy0), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
    .out_idx(i0), .out_last(l0), .done(done0));

  array_scan_out #(.SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .arr_flat(arr_flat),
    .busy(busy1), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .out_idx(i1), .out_last(l1), .done(done1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard monitors: pop an expected beat on every transfer, and
  // verify payload holds while stalled.
  logic        stall0 = 1'b0, stall1 = 1'b0;
  logic [12:0] held0, held1;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall0 = 1'b0;
    end else begin
      if (v0 && stall0) chk("hold0", {d0, i0, l0}, held0);
      if (v0 && out_ready) begin
        if (q0.size() == 0) begin
          total++;
          $display("FAIL extra0: got beat %0h expected none", {d0, i0, l0});
        end else chk("beat0", {d0, i0, l0}, q0.pop_front());
      end
      stall0 = v0 && !out_ready;
      held0  = {d0, i0, l0};
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      stall1 = 1'b0;
    end else begin
      if (v1 && stall1) chk("hold1", {d1, i1, l1}, held1);
      if (v1 && out_ready) begin
        if (q1.size() == 0) begin
          total++;
          $display("FAIL extra1: got beat %0h expected none", {d1, i1, l1});
        end else chk("beat1", {d1, i1, l1}, q1.pop_front());
      end
      stall1 = v1 && !out_ready;
      held1  = {d1, i1, l1};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc();
    for (int i = 0; i < 16; i++) arr_flat[i*8 +: 8] = 8'(i + 1);
  endtask

  task automatic push_inc(input int cnt);
    for (int i = 0; i < cnt; i++) q0.push_back({8'(i + 1), 4'(i), (i == 15)});
  endtask

  // Caller has just ticked the start edge; n counts cycles since it.
  task automatic wait_done(input bit which, input int exp_n, input string nm);
    int n = 1;
    while (!(which ? done1 : done0) && n < 80) begin
      tick();
      n++;
    end
    chk({nm, "_done_cycle"}, n, exp_n);
    chk({nm, "_busy_at_done"}, which ? busy1 : busy0, 0);
    tick();
    chk({nm, "_done_pulse"}, which ? done1 : done0, 0);
  endtask

  task automatic go(input bit which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] pat;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; out_ready = 1'b1; arr_flat = '0;
    tick(); tick();
    chk("reset0", {busy0, v0, d0, i0, l0, done0}, 0);
    chk("reset1", {busy1, v1, d1, i1, l1, done1}, 0);
    rst_n = 1'b1;
    tick();

    // 1: incrementing array, full-rate stream
    set_inc(); push_inc(16);
    go(0);
    chk("s1_first_valid", {v0, busy0, i0}, {1'b1, 1'b1, 4'd0});
    wait_done(0, 17, "s1");
    chk("s1_drained", q0.size(), 0);

    // 2: sparse array with zero skipping
    arr_flat = '0;
    arr_flat[3*8 +: 8] = 8'hA5; arr_flat[7*8 +: 8] = 8'h3C; arr_flat[15*8 +: 8] = 8'hFF;
    q1.push_back({8'hA5, 4'd3, 1'b0});
    q1.push_back({8'h3C, 4'd7, 1'b0});
    q1.push_back({8'hFF, 4'd15, 1'b1});
    go(1);
    wait_done(1, 4, "s2");
    chk("s2_drained", q1.size(), 0);
    // all-zero array: straight to done
    arr_flat = '0;
    go(1);
    chk("s2z_done", {done1, v1, busy1}, 3'b100);
    tick();
    chk("s2z_pulse", done1, 0);

    // 3: backpressure pattern 1,0,0,1
    pat = 4'b1001;
    set_inc(); push_inc(16);
    go(0);
    n = 1;
    while (!done0 && n < 120) begin
      out_ready = pat[3 - (n % 4)];
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("s3_done_seen", done0, 1);
    chk("s3_drained", q0.size(), 0);
    tick();

    // 4: array change and start pulses mid-scan have no effect
    set_inc(); push_inc(16);
    go(0);
    arr_flat = {16{8'hEE}};
    n = 1;
    while (!done0 && n < 80) begin
      start0 = (n == 3 || n == 4);
      tick();
      n++;
    end
    chk("s4_done_cycle", n, 17);
    start0 = 1'b1;             // start while done is high
    tick();
    start0 = 1'b0;
    chk("s4_idle_after", {busy0, v0}, 0);
    tick();
    chk("s4_no_restart", {busy0, v0, done0}, 0);
    chk("s4_drained", q0.size(), 0);

    // 5: async reset after five beats
    set_inc(); push_inc(5);
    go(0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("s5_reset_outs", {busy0, v0, d0, i0, l0, done0}, 0);
    chk("s5_drained", q0.size(), 0);
    tick();
    chk("s5_no_done_a", done0, 0);
    tick();
    chk("s5_no_done_b", done0, 0);
    rst_n = 1'b1;
    tick();
    push_inc(16);
    go(0);
    chk("s5_restart_idx", {v0, i0}, {1'b1, 4'd0});
    wait_done(0, 17, "s5");
    chk("s5_drained2", q0.size(), 0);

    // 6: single nonzero entry at index 0
    arr_flat = '0;
    arr_flat[7:0] = 8'h80;
    q1.push_back({8'h80, 4'd0, 1'b1});
    go(1);
    wait_done(1, 2, "s6");
    chk("s6_drained", q1.size(), 0);

    tick();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
